bit_vault_mp: RTL and testbench

Parametrised multi-port successor to the 4×8 register file. Storage is DEPTH × DATA_W with one byte-enabled write port and two independent registered read ports, with write-first bypass between them. A built-in clear sequencer zeroes the array one entry per cycle. The block is the general-purpose local scratch store for datapath blocks that need concurrent reads and a bulk reset without a global reset pulse.

---
 rtl/bit_vault_pkg.sv | 14 +
 rtl/bit_vault_rd_port.sv | 52 +++++
 rtl/bit_vault_mp.sv | 133 +++++++++++++
 tb/tb_bit_vault_mp.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_vault_pkg.sv
// Shared definitions for the bit_vault_mp scratch store: clear-sequencer
// state encoding and default geometry.
package bit_vault_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/bit_vault_rd_port.sv
// One registered read port: selects the addressed entry, forwards a same-cycle
// write to the same address (write-first), and flags each update with a valid pulse.
module bit_vault_rd_port
  import bit_vault_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] mem [DEPTH],
  input  logic              byp_en,
  input  logic [AW-1:0]     byp_addr,
  input  logic [DATA_W-1:0] byp_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (rd_en) begin
      rd_valid_d = 1'b1;
      // byp_data is already the merged word, so partial writes forward correctly
      if (byp_en && (byp_addr == rd_addr)) begin
        rd_data_d = byp_data;
      end else begin
        rd_data_d = mem[rd_addr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/bit_vault_mp.sv
// DEPTH x DATA_W scratch store with one byte-enabled write port, two registered
// read ports with write-first bypass, and a one-entry-per-cycle clear sequencer.
module bit_vault_mp
  import bit_vault_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int AW     = $clog2(DEPTH),
  localparam int NB     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NB-1:0]     wr_be,
  output logic              wr_drop,
  input  logic              rd_en_a,
  input  logic [AW-1:0]     rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  clr_state_e        state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic              wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              eff_en;
  logic [AW-1:0]     eff_addr;
  logic [DATA_W-1:0] eff_word;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_drop_d = 1'b0;
    eff_en    = 1'b0;
    eff_addr  = wr_addr;
    eff_word  = mem_q[wr_addr];

    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // The clear owns the single write path; user writes are dropped meanwhile
    if (state_q == ST_CLEAR) begin
      eff_en    = 1'b1;
      eff_addr  = clr_cnt_q;
      eff_word  = '0;
      wr_drop_d = wr_en && (|wr_be);
    end else if (wr_en && (|wr_be)) begin
      eff_en = 1'b1;
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          eff_word[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (eff_en) begin
      mem_q[eff_addr] <= eff_word;
    end
  end

  bit_vault_rd_port #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rd_a (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en_a),
    .rd_addr  (rd_addr_a),
    .mem      (mem_q),
    .byp_en   (eff_en),
    .byp_addr (eff_addr),
    .byp_data (eff_word),
    .rd_data  (rd_data_a),
    .rd_valid (rd_valid_a)
  );

  bit_vault_rd_port #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rd_b (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en_b),
    .rd_addr  (rd_addr_b),
    .mem      (mem_q),
    .byp_en   (eff_en),
    .byp_addr (eff_addr),
    .byp_data (eff_word),
    .rd_data  (rd_data_b),
    .rd_valid (rd_valid_b)
  );

  assign wr_drop  = wr_drop_q;
  assign clr_busy = (state_q == ST_CLEAR);
  assign clr_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_bit_vault_mp.sv
// Directed bench for bit_vault_mp (16-bit words, 16 entries): reads are scored
// through per-port expectation queues drained by an independent monitor.
module tb_bit_vault_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [15:0] wr_data = 16'h0;
  logic [1:0]  wr_be = 2'b00;
  logic        wr_drop;
  logic        rd_en_a = 1'b0;
  logic [3:0]  rd_addr_a = 4'd0;
  logic [15:0] rd_data_a;
  logic        rd_valid_a;
  logic        rd_en_b = 1'b0;
  logic [3:0]  rd_addr_b = 4'd0;
  logic [15:0] rd_data_b;
  logic        rd_valid_b;
  logic        clr_req = 1'b0;
  logic        clr_busy;
  logic        clr_done;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t mon_a, mon_b;
  int   cyc = 0;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  bit_vault_mp #(.DATA_W(16), .DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_be      (wr_be),
    .wr_drop    (wr_drop),
    .rd_en_a    (rd_en_a),
    .rd_addr_a  (rd_addr_a),
    .rd_data_a  (rd_data_a),
    .rd_valid_a (rd_valid_a),
    .rd_en_b    (rd_en_b),
    .rd_addr_b  (rd_addr_b),
    .rd_data_b  (rd_data_b),
    .rd_valid_b (rd_valid_b),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each call owns one clock cycle: drive after the edge, return at the falling edge
  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                               input logic [1:0] be,
                               input logic ea, input logic [3:0] aa, input logic [15:0] xa,
                               input logic eb, input logic [3:0] ab, input logic [15:0] xb,
                               input logic cr);
    exp_t e;
    @(posedge clk);
    #1;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en_a = ea; rd_addr_a = aa;
    rd_en_b = eb; rd_addr_b = ab;
    clr_req = cr;
    if (ea) begin e.data = xa; e.cyc = cyc; exp_a.push_back(e); end
    if (eb) begin e.data = xb; e.cyc = cyc; exp_b.push_back(e); end
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);
  endtask

  task automatic writeWord(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    applyStimulus(1'b1, a, d, be, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);
  endtask

  task automatic readBoth(input logic [3:0] aa, input logic [15:0] xa,
                          input logic [3:0] ab, input logic [15:0] xb);
    applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, aa, xa, 1'b1, ab, xb, 1'b0);
  endtask

  task automatic runClear();
    for (int i = 0; i < 16; i++) begin
      idle();
      checkOutput("clr_busy_run", {31'b0, clr_busy}, 32'd1);
      checkOutput("clr_done_run", {31'b0, clr_done}, 32'd0);
    end
    idle();
    checkOutput("clr_busy_end", {31'b0, clr_busy}, 32'd0);
    checkOutput("clr_done_end", {31'b0, clr_done}, 32'd1);
    idle();
    checkOutput("clr_done_pulse", {31'b0, clr_done}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rd_valid_a) begin
      if (exp_a.size() == 0) begin
        checkOutput("rd_valid_a_spurious", 32'd1, 32'd0);
      end else begin
        mon_a = exp_a.pop_front();
        checkOutput("rd_data_a", {16'h0, rd_data_a}, {16'h0, mon_a.data});
        checkOutput("rd_latency_a", cyc, mon_a.cyc + 1);
      end
    end else if (exp_a.size() > 0 && cyc > exp_a[0].cyc + 1) begin
      void'(exp_a.pop_front());
      checkOutput("rd_valid_a_missing", 32'd0, 32'd1);
    end
    if (rd_valid_b) begin
      if (exp_b.size() == 0) begin
        checkOutput("rd_valid_b_spurious", 32'd1, 32'd0);
      end else begin
        mon_b = exp_b.pop_front();
        checkOutput("rd_data_b", {16'h0, rd_data_b}, {16'h0, mon_b.data});
        checkOutput("rd_latency_b", cyc, mon_b.cyc + 1);
      end
    end else if (exp_b.size() > 0 && cyc > exp_b[0].cyc + 1) begin
      void'(exp_b.pop_front());
      checkOutput("rd_valid_b_missing", 32'd0, 32'd1);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    #2 rst = 1'b1;
    #2;
    checkOutput("rst_rd_data_a",  {16'h0, rd_data_a}, 32'd0);
    checkOutput("rst_rd_data_b",  {16'h0, rd_data_b}, 32'd0);
    checkOutput("rst_rd_valid_a", {31'b0, rd_valid_a}, 32'd0);
    checkOutput("rst_rd_valid_b", {31'b0, rd_valid_b}, 32'd0);
    checkOutput("rst_wr_drop",    {31'b0, wr_drop}, 32'd0);
    checkOutput("rst_clr_busy",   {31'b0, clr_busy}, 32'd0);
    checkOutput("rst_clr_done",   {31'b0, clr_done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    // Every entry reads zero after reset
    for (int i = 0; i < 16; i++) readBoth(4'(i), 16'h0000, 4'(15 - i), 16'h0000);

    // Byte-enabled writes and dual read of one address
    writeWord(4'd3, 16'h00A5, 2'b01);
    readBoth(4'd3, 16'h00A5, 4'd3, 16'h00A5);
    writeWord(4'd7, 16'h1234, 2'b11);
    writeWord(4'd7, 16'hBEEF, 2'b01);
    readBoth(4'd7, 16'h12EF, 4'd3, 16'h00A5);
    writeWord(4'd7, 16'hCD00, 2'b10);
    applyStimulus(1'b1, 4'd7, 16'hFFFF, 2'b00, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 16'hCDEF, 1'b0);
    idle();
    checkOutput("wr_drop_be_zero", {31'b0, wr_drop}, 32'd0);

    // Write-first bypass, full and partial
    applyStimulus(1'b1, 4'd5, 16'h003C, 2'b11, 1'b1, 4'd5, 16'h003C, 1'b1, 4'd6, 16'h0000, 1'b0);
    applyStimulus(1'b1, 4'd7, 16'h0011, 2'b01, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 16'hCD11, 1'b0);

    // Fill, then clear with mid-clear reads, an ignored request and a dropped write
    for (int i = 0; i < 16; i++) writeWord(4'(i), 16'hFFFF, 2'b11);
    applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1);
    checkOutput("clr_busy_req_cycle", {31'b0, clr_busy}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 3)
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1);
      else if (i == 5)
        readBoth(4'd15, 16'hFFFF, 4'd2, 16'h0000);
      else if (i == 8)
        readBoth(4'd8, 16'h0000, 4'd9, 16'hFFFF);
      else if (i == 10)
        writeWord(4'd12, 16'h1111, 2'b11);
      else
        idle();
      checkOutput("clr_busy", {31'b0, clr_busy}, 32'd1);
      checkOutput("clr_done", {31'b0, clr_done}, 32'd0);
      checkOutput("wr_drop",  {31'b0, wr_drop}, (i == 11) ? 32'd1 : 32'd0);
    end
    writeWord(4'd4, 16'h4444, 2'b11);
    checkOutput("clr_busy_done", {31'b0, clr_busy}, 32'd0);
    checkOutput("clr_done_done", {31'b0, clr_done}, 32'd1);
    idle();
    checkOutput("clr_done_after", {31'b0, clr_done}, 32'd0);
    checkOutput("clr_busy_after", {31'b0, clr_busy}, 32'd0);
    idle();
    checkOutput("clr_req_not_queued", {31'b0, clr_busy}, 32'd0);
    for (int i = 0; i < 16; i++)
      readBoth(4'(i), (i == 4) ? 16'h4444 : 16'h0000, 4'(i), (i == 4) ? 16'h4444 : 16'h0000);

    // Asynchronous reset in the middle of a clear
    writeWord(4'd9, 16'h9999, 2'b11);
    writeWord(4'd14, 16'hEEEE, 2'b11);
    applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) readBoth(4'd14, 16'hEEEE, 4'd9, 16'h9999);
      else idle();
    end
    @(posedge clk);
    #1 checkOutput("busy_before_rst", {31'b0, clr_busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_rd_data_a",  {16'h0, rd_data_a}, 32'd0);
    checkOutput("midrst_rd_data_b",  {16'h0, rd_data_b}, 32'd0);
    checkOutput("midrst_rd_valid_a", {31'b0, rd_valid_a}, 32'd0);
    checkOutput("midrst_clr_busy",   {31'b0, clr_busy}, 32'd0);
    checkOutput("midrst_clr_done",   {31'b0, clr_done}, 32'd0);
    checkOutput("midrst_wr_drop",    {31'b0, wr_drop}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    idle();
    checkOutput("post_rst_busy", {31'b0, clr_busy}, 32'd0);
    for (int i = 0; i < 16; i++) readBoth(4'(i), 16'h0000, 4'(15 - i), 16'h0000);
    writeWord(4'd6, 16'h6666, 2'b11);
    applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1);
    runClear();
    readBoth(4'd6, 16'h0000, 4'd15, 16'h0000);

    // Write and clear request in the same idle cycle
    applyStimulus(1'b1, 4'd0, 16'h0077, 2'b11, 1'b1, 4'd0, 16'h0077, 1'b0, 4'd0, 16'h0, 1'b1);
    applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'h0000, 1'b0);
    checkOutput("wrclr_busy", {31'b0, clr_busy}, 32'd1);
    for (int i = 1; i < 16; i++) begin
      idle();
      checkOutput("wrclr_busy_run", {31'b0, clr_busy}, 32'd1);
    end
    idle();
    checkOutput("wrclr_done", {31'b0, clr_done}, 32'd1);
    readBoth(4'd0, 16'h0000, 4'd1, 16'h0000);

    repeat (3) idle();
    checkOutput("queue_a_drained", exp_a.size(), 32'd0);
    checkOutput("queue_b_drained", exp_b.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
